// File: rtl/m_pkg.sv
// ---------------------------------------------------------------------------
// m_pkg
// Shared types for the m ingress path and its packet arbiter.
//   in_t        : one ingress beat (sop, eop, length, data)
//   len_t       : packet length field
//   data_t      : beat payload
//   arb_state_e : packet arbiter state (idle / packet in flight)
//   N_REQ_DEFAULT : default number of requesters feeding the arbiter
// ---------------------------------------------------------------------------
package m_pkg;

    localparam int LEN_W         = 16;
    localparam int DATA_W        = 32;
    localparam int N_REQ_DEFAULT = 4;

    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  sop;
        logic  eop;
        len_t  length;
        data_t data;
    } in_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/m_rr_pick.sv
// ---------------------------------------------------------------------------
// m_rr_pick
// Rotating-priority picker: grants the first requesting bit at or after the
// pointer, wrapping modulo N. Purely combinational.
//   req_i : request vector
//   ptr_i : index of the highest-priority requester this cycle
//   gnt_o : one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module m_rr_pick
    import m_pkg::*;
#(
    parameter int N = N_REQ_DEFAULT
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    int   idx;
    logic found;

    // Walk the requesters starting at the pointer; the first hit wins and
    // blocks every later position in the walk.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_ingress_arb.sv
// ---------------------------------------------------------------------------
// m_ingress_arb
// Packet-granularity round-robin arbiter in front of the m ingress. Once a
// requester's sop beat is accepted it owns the output until its eop beat is
// accepted. Accepted beats are forwarded bit-exact one cycle later.
//   clk, rst      : clock, asynchronous active-high reset
//   req_vld_w     : per-requester beat valid
//   req_w         : per-requester beat
//   req_accept_w  : combinational consume strobe, at most one bit set
//   out_vld_r     : registered beat valid toward the m ingress
//   out_r         : registered beat (holds when no beat was accepted)
//   out_owner_r   : requester index of the beat on out_r
//   err_r         : one-cycle protocol-error pulse
// ---------------------------------------------------------------------------
module m_ingress_arb
    import m_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_vld_w,
    input  in_t                      req_w [N_REQ],
    output logic [N_REQ-1:0]         req_accept_w,
    output logic                     out_vld_r,
    output in_t                      out_r,
    output logic [$clog2(N_REQ)-1:0] out_owner_r,
    output logic                     err_r
);

    localparam int OW = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             err_d;

    logic [N_REQ-1:0] sop_cand;
    logic [N_REQ-1:0] pick_gnt;
    logic             stray_any;
    logic             acc_any;
    logic [OW-1:0]    acc_idx;
    in_t              acc_beat;

    // Only sop beats may open a packet; a valid non-sop beat seen while idle
    // is a protocol error and is left stalled.
    always_comb begin
        sop_cand  = '0;
        stray_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sop_cand[i] = req_vld_w[i] & req_w[i].sop;
            if (req_vld_w[i] && !req_w[i].sop) begin
                stray_any = 1'b1;
            end
        end
    end

    m_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req_i (sop_cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt)
    );

    // Idle: the rotating pick decides. Busy: the owner is accepted whenever
    // it is valid, everyone else waits. Nothing is consumed during reset.
    always_comb begin
        req_accept_w = '0;
        if (!rst) begin
            if (state_q == ARB_IDLE) begin
                req_accept_w = pick_gnt;
            end else begin
                req_accept_w[owner_q] = req_vld_w[owner_q];
            end
        end
    end

    // Encode the one-hot accept and select the consumed beat.
    always_comb begin
        acc_any  = |req_accept_w;
        acc_idx  = '0;
        acc_beat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_accept_w[i]) begin
                acc_idx  = OW'(i);
                acc_beat = req_w[i];
            end
        end
    end

    // Next-state logic. The pointer moves past a requester only when it
    // opens a packet; a sop arriving mid-packet is forwarded but flagged.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        err_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                err_d = stray_any;
                if (acc_any) begin
                    rr_ptr_d = (acc_idx == OW'(N_REQ - 1)) ? '0 : acc_idx + 1'b1;
                    owner_d  = acc_idx;
                    if (!acc_beat.eop) begin
                        state_d = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                err_d = acc_any & acc_beat.sop;
                if (acc_any && acc_beat.eop) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Output stage: beat and owner only load on an accept so out_r keeps its
    // last value through idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_r   <= 1'b0;
            out_r       <= '0;
            out_owner_r <= '0;
            err_r       <= 1'b0;
        end else begin
            out_vld_r <= acc_any;
            err_r     <= err_d;
            if (acc_any) begin
                out_r       <= acc_beat;
                out_owner_r <= acc_idx;
            end
        end
    end

endmodule

// File: tb/tb_m_ingress_arb.sv
// ---------------------------------------------------------------------------
// tb_m_ingress_arb
// Self-checking bench for m_ingress_arb. Each requester owns a queue of beats
// it presents (holding a beat until consumed); a packet-level reference model
// predicts accepts, forwarded beats, owner and error pulses.
// ---------------------------------------------------------------------------
module tb_m_ingress_arb;
    import m_pkg::*;

    localparam int N  = 4;
    localparam int OW = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_vld_w;
    in_t           req_w [N];
    logic [N-1:0]  req_accept_w;
    logic          out_vld_r;
    in_t           out_r;
    logic [OW-1:0] out_owner_r;
    logic          err_r;

    m_ingress_arb #(
        .N_REQ (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld_w    (req_vld_w),
        .req_w        (req_w),
        .req_accept_w (req_accept_w),
        .out_vld_r    (out_vld_r),
        .out_r        (out_r),
        .out_owner_r  (out_owner_r),
        .err_r        (err_r)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int  checkCount;
    int  passCount;
    in_t txq [N][$];
    int  gapCnt [N];
    int  vldPct;

    // Reference model: packet ownership, rotating priority and predicted outputs.
    bit            mBusy;
    int            mOwner;
    int            mPtr;
    logic [N-1:0]  expAcc;
    logic          expVld;
    in_t           expOut;
    logic [OW-1:0] expOwner;
    logic          expErr;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mBusy    = 1'b0;
        mOwner   = 0;
        mPtr     = 0;
        expAcc   = '0;
        expVld   = 1'b0;
        expOut   = '0;
        expOwner = '0;
        expErr   = 1'b0;
    endtask

    // Queue one packet of nBeats for requester r; midSop plants a second sop.
    task automatic pushPacket(input int r, input int nBeats, input int len, input bit midSop);
        in_t beat;
        for (int b = 0; b < nBeats; b++) begin
            beat.sop    = (b == 0) || (midSop && b == 1);
            beat.eop    = (b == nBeats - 1);
            beat.length = len_t'(len);
            beat.data   = data_t'($urandom);
            txq[r].push_back(beat);
        end
    endtask

    // Present the head of each queue (subject to gaps and random idling).
    task automatic applyStimulus();
        logic [63:0] junk;
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() > 0 && gapCnt[i] == 0 && int'($urandom_range(99)) < vldPct) begin
                req_vld_w[i] = 1'b1;
                req_w[i]     = txq[i][0];
            end else begin
                junk         = {$urandom, $urandom};
                req_vld_w[i] = 1'b0;
                req_w[i]     = junk[$bits(in_t)-1:0];
            end
            if (gapCnt[i] > 0) gapCnt[i]--;
        end
    endtask

    // Predict this cycle's accept and next cycle's outputs from packet rules.
    task automatic modelStep();
        int  g;
        int  idx;
        bit  stray;
        in_t b;
        expAcc = '0;
        g      = -1;
        stray  = 1'b0;
        if (mBusy) begin
            if (req_vld_w[mOwner]) g = mOwner;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (g < 0 && req_vld_w[idx] && req_w[idx].sop) g = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_vld_w[i] && !req_w[i].sop) stray = 1'b1;
        end
        expErr = mBusy ? 1'b0 : stray;
        expVld = (g >= 0);
        if (g >= 0) begin
            b         = req_w[g];
            expAcc[g] = 1'b1;
            expOut    = b;
            expOwner  = OW'(g);
            if (mBusy) begin
                if (b.sop) expErr = 1'b1;
                if (b.eop) mBusy = 1'b0;
            end else begin
                mPtr = (g + 1) % N;
                if (!b.eop) begin
                    mBusy  = 1'b1;
                    mOwner = g;
                end
            end
            void'(txq[g].pop_front());
        end
    endtask

    // One full cycle: drive, check combinational accept, clock, check outputs.
    task automatic runCycle();
        applyStimulus();
        #1;
        modelStep();
        checkOutput("accept", 64'(req_accept_w), 64'(expAcc));
        @(posedge clk);
        #1;
        checkOutput("outVld",   64'(out_vld_r),   64'(expVld));
        checkOutput("outBeat",  64'(out_r),       64'(expOut));
        checkOutput("outOwner", 64'(out_owner_r), 64'(expOwner));
        checkOutput("err",      64'(err_r),       64'(expErr));
    endtask

    initial begin
        in_t bad;
        checkCount = 0;
        passCount  = 0;
        vldPct     = 100;
        for (int i = 0; i < N; i++) begin
            gapCnt[i] = 0;
            req_w[i]  = '0;
        end
        req_vld_w = '0;
        rst       = 1'b1;
        modelReset();

        // Reset values, and no accept even with sop beats offered during reset.
        #2;
        for (int i = 0; i < N; i++) begin
            req_w[i].sop = 1'b1;
        end
        req_vld_w = '1;
        #1;
        checkOutput("rstAccept", 64'(req_accept_w), 64'(0));
        checkOutput("rstVld",    64'(out_vld_r),    64'(0));
        checkOutput("rstBeat",   64'(out_r),        64'(0));
        checkOutput("rstOwner",  64'(out_owner_r),  64'(0));
        checkOutput("rstErr",    64'(err_r),        64'(0));
        req_vld_w = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester, 3-beat packet of length 12.
        pushPacket(0, 3, 12, 1'b0);
        runCycle();
        checkOutput("singleLen",   64'(out_r.length), 64'(12));
        checkOutput("singleSop",   64'(out_r.sop),    64'(1));
        checkOutput("singleOwner", 64'(out_owner_r),  64'(0));
        runCycle();
        runCycle();
        checkOutput("singleEop", 64'(out_r.eop), 64'(1));
        checkOutput("singleErr", 64'(err_r),     64'(0));
        runCycle();

        // Owner gap: r1 idles 5 cycles mid-packet while r2 waits.
        pushPacket(1, 3, 5, 1'b0);
        pushPacket(2, 2, 6, 1'b0);
        runCycle();
        checkOutput("gapFirstOwner", 64'(out_owner_r), 64'(1));
        gapCnt[1] = 5;
        for (int c = 0; c < 5; c++) begin
            runCycle();
            checkOutput("gapOutVld", 64'(out_vld_r), 64'(0));
        end
        runCycle();
        runCycle();
        checkOutput("gapR1Eop", 64'(out_r.eop), 64'(1));
        runCycle();
        checkOutput("gapThenR2", 64'(out_owner_r), 64'(2));
        runCycle();

        // Stray non-sop beat in idle: stalled and flagged.
        bad.sop    = 1'b0;
        bad.eop    = 1'b1;
        bad.length = len_t'(1);
        bad.data   = data_t'(32'hdead_beef);
        txq[2].push_back(bad);
        runCycle();
        checkOutput("strayErr", 64'(err_r),     64'(1));
        checkOutput("strayVld", 64'(out_vld_r), 64'(0));
        txq[2].delete();
        runCycle();
        checkOutput("errClear", 64'(err_r), 64'(0));

        // Owner sends sop mid-packet: forwarded and flagged.
        pushPacket(0, 3, 8, 1'b1);
        runCycle();
        runCycle();
        checkOutput("midSopErr", 64'(err_r),     64'(1));
        checkOutput("midSopFwd", 64'(out_r.sop), 64'(1));
        runCycle();

        // Wrap: move the pointer to 3, then r0 and r3 contend.
        pushPacket(2, 1, 1, 1'b0);
        runCycle();
        pushPacket(0, 1, 2, 1'b0);
        pushPacket(3, 1, 3, 1'b0);
        runCycle();
        checkOutput("wrapFirst", 64'(out_owner_r), 64'(3));
        runCycle();
        checkOutput("wrapNext", 64'(out_owner_r), 64'(0));

        // Reset on beat 2 of a 4-beat packet.
        pushPacket(0, 4, 16, 1'b0);
        runCycle();
        applyStimulus();
        rst = 1'b1;
        #1;
        checkOutput("rstMidVld", 64'(out_vld_r),    64'(0));
        checkOutput("rstMidAcc", 64'(req_accept_w), 64'(0));
        modelReset();
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full contention straight after reset: packets in order 0,1,2,3.
        for (int i = 0; i < N; i++) begin
            pushPacket(i, 3, 10 + i, 1'b0);
        end
        for (int c = 0; c < 12; c++) begin
            runCycle();
            checkOutput("contOwner", 64'(out_owner_r), 64'(c / 3));
        end

        // Randomised traffic with idling requesters and occasional mid-packet sop.
        vldPct = 70;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (txq[i].size() == 0 && $urandom_range(99) < 30) begin
                    pushPacket(i, int'($urandom_range(4, 1)), int'($urandom_range(64, 1)),
                               $urandom_range(99) < 10);
                end
                if (gapCnt[i] == 0 && $urandom_range(99) < 3) begin
                    gapCnt[i] = int'($urandom_range(4, 1));
                end
            end
            runCycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
